regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (reg_write/wr/wd) between two writeback requesters:
//  A = ALU result path (default priority), B = load/multicycle unit. Valid/ready handshake per requester;

---
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback requesters.
//   A is the ALU result path and has priority by default. B is the load/multicycle
//   unit. An anti-starvation FSM gives B priority after STARVE_LIMIT consecutive
//   lost cycles. The write port is driven from registers, so an accepted write
//   reaches the regfile one cycle after the handshake. Writes to x0 are acknowledged
//   at once and never use the port.
//
//   Optional feature: define WB_STATS_EN to count A/B contention cycles on
//   `conflicts`. Without it, `conflicts` is tied to zero.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous reset, active low
//   a_valid/a_rd/a_data  requester A write request
//   a_ready              A request accepted this cycle (combinational)
//   b_valid/b_rd/b_data  requester B write request
//   b_ready              B request accepted this cycle (combinational)
//   reg_write/wr/wd      registered regfile write port
//   conflicts            saturating count of A/B same-cycle contention
//
// State | meaning
//   A_PRIO | A wins a contended cycle, B's losses are counted
//   B_PRIO | B wins its next request, then priority goes back to A
module regfile_wb_arbiter #(
  parameter int n            = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [4:0]   a_rd,
  input  logic [n-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [4:0]   b_rd,
  input  logic [n-1:0] b_data,
  output logic         b_ready,
  output logic         reg_write,
  output logic [4:0]   wr,
  output logic [n-1:0] wd,
  output logic [15:0]  conflicts
);

  typedef enum logic {
    A_PRIO = 1'b0,
    B_PRIO = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             a_zero;
  logic             b_zero;
  logic             a_req;
  logic             b_req;
  logic             grant_a;
  logic             grant_b;

  // x0 writes are acknowledged regardless of the other requester and never
  // compete for the port.
  always_comb begin
    a_zero  = a_valid && (a_rd == 5'd0);
    b_zero  = b_valid && (b_rd == 5'd0);
    a_req   = a_valid && (a_rd != 5'd0);
    b_req   = b_valid && (b_rd != 5'd0);
    grant_a = a_req && ((state == A_PRIO) || !b_req);
    grant_b = b_req && ((state == B_PRIO) || !a_req);
    a_ready = a_zero || grant_a;
    b_ready = b_zero || grant_b;
  end

  // Counts only cycles where B wanted the port and A got it; any other cycle
  // (B granted or B idle) breaks the run.
  always_comb begin
    starve_cnt_nxt = '0;
    if (b_req && grant_a) begin
      if (starve_cnt == LIMIT) begin
        starve_cnt_nxt = starve_cnt;
      end else begin
        starve_cnt_nxt = starve_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= A_PRIO;
      starve_cnt <= '0;
      reg_write  <= 1'b0;
      wr         <= '0;
      wd         <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      reg_write  <= grant_a || grant_b;
      if (grant_a) begin
        wr <= a_rd;
        wd <= a_data;
      end else if (grant_b) begin
        wr <= b_rd;
        wd <= b_data;
      end
      case (state)
        A_PRIO: begin
          // Looking at the next count makes the switch visible in the cycle
          // right after the limit-th loss.
          if (starve_cnt_nxt == LIMIT) begin
            state <= B_PRIO;
          end
        end
        B_PRIO: begin
          if (grant_b) begin
            state <= A_PRIO;
          end
        end
        default: state <= A_PRIO;
      endcase
    end
  end

`ifdef WB_STATS_EN
  logic [15:0] conflict_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= 16'h0;
    end else if (a_req && b_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign conflicts = conflict_cnt;
`else
  assign conflicts = 16'h0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Each step drives both requesters,
// checks the combinational ready outputs mid-cycle, queues the expected
// regfile write and compares it after the next rising edge.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        reg_write;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [15:0] conflicts;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [4:0]  last_wr;
  logic [31:0] last_wd;
  int          exp_conf;

  regfile_wb_arbiter #(.n(32), .STARVE_LIMIT(3), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .reg_write (reg_write),
    .wr        (wr),
    .wd        (wd),
    .conflicts (conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Reset is asserted away from the edge, checked while
  // held, and released just after the following rising edge.
  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
    chk("rst_wr", {27'b0, wr}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_conflicts", {16'b0, conflicts}, 32'd0);
    sb_q.delete();
    last_wr  = 5'd0;
    last_wd  = 32'd0;
    exp_conf = 0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Called at posedge+1. ewr/ewd are ignored when no write is expected:
  // the port must then hold its previous address and data.
  task automatic step(input string tag,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic ear, input logic ebr,
                      input logic ewe, input logic [4:0] ewr, input logic [31:0] ewd);
    exp_t e;
    exp_t got;
    a_valid = av;
    a_rd    = ard;
    a_data  = ad;
    b_valid = bv;
    b_rd    = brd;
    b_data  = bd;
    @(negedge clk);
    chk({tag, "_a_ready"}, {31'b0, a_ready}, {31'b0, ear});
    chk({tag, "_b_ready"}, {31'b0, b_ready}, {31'b0, ebr});
    if (ewe) begin
      last_wr = ewr;
      last_wd = ewd;
    end
    e.we = ewe;
    e.wr = last_wr;
    e.wd = last_wd;
    sb_q.push_back(e);
`ifdef WB_STATS_EN
    if (av && (ard != 5'd0) && bv && (brd != 5'd0)) exp_conf++;
`endif
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, "_reg_write"}, {31'b0, reg_write}, {31'b0, got.we});
    chk({tag, "_wr"}, {27'b0, wr}, {27'b0, got.wr});
    chk({tag, "_wd"}, wd, got.wd);
    chk({tag, "_conflicts"}, {16'b0, conflicts}, 32'(exp_conf));
  endtask

  initial begin
    int          k;
    logic        b_win;
    logic [31:0] bdat;
    rst      = 1'b1;
    a_valid  = 1'b0;
    a_rd     = 5'd0;
    a_data   = 32'd0;
    b_valid  = 1'b0;
    b_rd     = 5'd0;
    b_data   = 32'd0;
    last_wr  = 5'd0;
    last_wd  = 32'd0;
    exp_conf = 0;

    do_reset();
    chk("rst_a_ready_idle", {31'b0, a_ready}, 32'd0);
    chk("rst_b_ready_idle", {31'b0, b_ready}, 32'd0);

    // A alone, then an idle cycle that must hold wr/wd
    step("a_only", 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF);
    step("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // B held against A: three losses, grant on the fourth, then A priority again
    step("starve_c0", 1, 3, 32'hA0, 1, 4, 32'hB4, 1, 0, 1, 3, 32'hA0);
    step("starve_c1", 1, 3, 32'hA1, 1, 4, 32'hB4, 1, 0, 1, 3, 32'hA1);
    step("starve_c2", 1, 3, 32'hA2, 1, 4, 32'hB4, 1, 0, 1, 3, 32'hA2);
    step("starve_c3", 1, 3, 32'hA3, 1, 4, 32'hB4, 0, 1, 1, 4, 32'hB4);
    step("starve_c4", 1, 3, 32'hA3, 1, 6, 32'hC6, 1, 0, 1, 3, 32'hA3);
    step("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // B priority survives a cycle where B is not requesting
    step("bprio_c0", 1, 11, 32'h10, 1, 12, 32'h12, 1, 0, 1, 11, 32'h10);
    step("bprio_c1", 1, 11, 32'h11, 1, 12, 32'h12, 1, 0, 1, 11, 32'h11);
    step("bprio_c2", 1, 11, 32'h12, 1, 12, 32'h12, 1, 0, 1, 11, 32'h12);
    step("bprio_aonly", 1, 11, 32'h13, 0, 0, 0, 1, 0, 1, 11, 32'h13);
    step("bprio_bwin", 1, 11, 32'h14, 1, 12, 32'h12, 0, 1, 1, 12, 32'h12);
    step("bprio_back_a", 1, 11, 32'h14, 1, 13, 32'h13, 1, 0, 1, 11, 32'h14);
    step("idle3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 absorption on either side, and both at once
    step("x0_a", 1, 0, 32'hAA, 1, 7, 32'h77, 1, 1, 1, 7, 32'h77);
    step("x0_b", 1, 8, 32'h88, 1, 0, 32'hBB, 1, 1, 1, 8, 32'h88);

    // Same destination: served in grant order, no merge
    step("same_rd_c1", 1, 9, 32'h1, 1, 9, 32'h2, 1, 0, 1, 9, 32'h1);
    step("same_rd_c2", 0, 0, 0, 1, 9, 32'h2, 0, 1, 1, 9, 32'h2);
    step("x0_both", 1, 0, 32'h5, 1, 0, 32'h6, 1, 1, 0, 0, 0);

    // Drive the FSM into B priority, reset right after a write lands
    step("pre_rst_c0", 1, 20, 32'h2000, 1, 21, 32'h21, 1, 0, 1, 20, 32'h2000);
    step("pre_rst_c1", 1, 20, 32'h2001, 1, 21, 32'h21, 1, 0, 1, 20, 32'h2001);
    step("pre_rst_c2", 1, 20, 32'h2002, 1, 21, 32'h21, 1, 0, 1, 20, 32'h2002);
    do_reset();
    step("post_rst_aprio", 1, 22, 32'h22, 1, 23, 32'h23, 1, 0, 1, 22, 32'h22);
    step("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Ten contention cycles from a clean reset: B wins every fourth cycle
    do_reset();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      b_win = ((i % 4) == 3);
      bdat  = 32'hB000 + 32'(k);
      if (b_win) begin
        step("contend", 1, 1, 32'(i), 1, 2, bdat, 0, 1, 1, 2, bdat);
        k++;
      end else begin
        step("contend", 1, 1, 32'(i), 1, 2, bdat, 1, 0, 1, 1, 32'(i));
      end
    end
`ifdef WB_STATS_EN
    chk("conflicts_10", {16'b0, conflicts}, 32'd10);
`else
    chk("conflicts_off", {16'b0, conflicts}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
